// File: rtl/matrix_cfg_ctrl.sv
// matrix_cfg_ctrl: stages 18 routing words, checks legality, commits them atomically to cfg_bus.
// Latency: cfg_done/cfg_err pulse and cfg_bus update 2 cycles after the last word's transfer.
// Backpressure: cfg_ready only in LOAD; optional readback port under MATRIX_CFG_READBACK_EN.
module matrix_cfg_ctrl #(
   parameter int NTB = 5,
   parameter int NLR = 4,
   parameter int CW  = 6
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cfg_start,
   input  logic                             cfg_abort,
   input  logic [CW-1:0]                    cfg_data,
   input  logic                             cfg_valid,
   output logic                             cfg_ready,
   output logic                             busy,
   output logic                             cfg_done,
   output logic                             cfg_err,
`ifdef MATRIX_CFG_READBACK_EN
   input  logic [4:0]                       rd_addr,
   output logic [CW-1:0]                    rd_data,
`endif
   output logic [(2*NTB+2*NLR)*CW-1:0]      cfg_bus
);

   localparam int NENT = 2*NTB + 2*NLR;
   localparam int CNTW = $clog2(NENT);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOAD   = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;

   localparam logic [2:0] SIDE_TOP    = 3'd1;
   localparam logic [2:0] SIDE_RIGHT  = 3'd2;
   localparam logic [2:0] SIDE_BOTTOM = 3'd3;
   localparam logic [2:0] SIDE_LEFT   = 3'd4;

   logic [1:0]      state;
   logic [CNTW-1:0] cnt;
   logic            err_flag;
   logic [CW-1:0]   shadow [NENT];
   logic            xfer;
   logic            illegal;
   logic [2:0]      side;
   logic [2:0]      idx;
   logic [2:0]      own_side;
   logic [2:0]      own_idx;

   assign cfg_ready = (state == LOAD);
   assign busy      = (state != IDLE);
   assign xfer      = cfg_valid && cfg_ready;
   assign side      = cfg_data[2:0];
   assign idx       = cfg_data[5:3];

   // The pin driven by the entry currently being loaded; selecting it would close a loop.
   always_comb begin
      own_side = SIDE_TOP;
      own_idx  = 3'(cnt);
      if (cnt >= CNTW'(NENT - NLR)) begin
         own_side = SIDE_RIGHT;
         own_idx  = 3'(cnt - CNTW'(NENT - NLR));
      end else if (cnt >= CNTW'(2*NTB)) begin
         own_side = SIDE_LEFT;
         own_idx  = 3'(cnt - CNTW'(2*NTB));
      end else if (cnt >= CNTW'(NTB)) begin
         own_side = SIDE_BOTTOM;
         own_idx  = 3'(cnt - CNTW'(NTB));
      end
   end

   always_comb begin
      illegal = 1'b0;
      case (side)
         3'd0:                  illegal = 1'b0;
         SIDE_TOP, SIDE_BOTTOM: illegal = (idx >= 3'(NTB));
         SIDE_RIGHT, SIDE_LEFT: illegal = (idx >= 3'(NLR));
         default:               illegal = 1'b1;
      endcase
      if ((side != 3'd0) && (side == own_side) && (idx == own_idx))
         illegal = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         err_flag <= 1'b0;
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
         cfg_bus  <= '0;
         for (int k = 0; k < NENT; k++)
            shadow[k] <= '0;
      end else begin
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_start) begin
                  state    <= LOAD;
                  cnt      <= '0;
                  err_flag <= 1'b0;
               end
            end
            LOAD: begin
               // Abort takes priority; a word offered in the same cycle is dropped.
               if (cfg_abort) begin
                  state <= IDLE;
               end else if (xfer) begin
                  shadow[cnt] <= cfg_data;
                  cnt         <= cnt + 1'b1;
                  if (illegal)
                     err_flag <= 1'b1;
                  if (cnt == CNTW'(NENT - 1))
                     state <= COMMIT;
               end
            end
            COMMIT: begin
               state <= IDLE;
               if (err_flag) begin
                  cfg_err <= 1'b1;
               end else begin
                  cfg_done <= 1'b1;
                  for (int k = 0; k < NENT; k++)
                     cfg_bus[k*CW +: CW] <= shadow[k];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MATRIX_CFG_READBACK_EN
   logic [CW-1:0] rd_next;

   always_comb begin
      rd_next = '0;
      for (int k = 0; k < NENT; k++)
         if (rd_addr == 5'(k))
            rd_next = cfg_bus[k*CW +: CW];
   end

   always_ff @(posedge clk) begin
      if (rst)
         rd_data <= '0;
      else
         rd_data <= rd_next;
   end
`endif

endmodule

// File: tb/tb_matrix_cfg_ctrl.sv
// Bench for matrix_cfg_ctrl: random and directed loads checked by a scoreboard against a legality model.
module tb_matrix_cfg_ctrl;

   localparam int NTB  = 5;
   localparam int NLR  = 4;
   localparam int CW   = 6;
   localparam int NENT = 2*NTB + 2*NLR;
   localparam int BW   = NENT*CW;

   typedef logic [CW-1:0] words_t [NENT];
   typedef struct {
      bit            ok;
      logic [BW-1:0] bus;
      int            cyc;
   } exp_t;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          cfg_start = 1'b0;
   logic          cfg_abort = 1'b0;
   logic          cfg_valid = 1'b0;
   logic [CW-1:0] cfg_data  = '0;
   logic          cfg_ready;
   logic          busy;
   logic          cfg_done;
   logic          cfg_err;
   logic [BW-1:0] cfg_bus;
`ifdef MATRIX_CFG_READBACK_EN
   logic [4:0]    rd_addr = '0;
   logic [CW-1:0] rd_data;
`endif

   exp_t          sbq [$];
   exp_t          e;
   int            n_cmp     = 0;
   int            n_fail    = 0;
   int            cyc       = 0;
   int            last_xfer = 0;
   logic          rst_q     = 1'b1;
   logic [BW-1:0] exp_bus   = '0;
   logic [BW-1:0] model_bus = '0;

   matrix_cfg_ctrl #(.NTB(NTB), .NLR(NLR), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_start (cfg_start),
      .cfg_abort (cfg_abort),
      .cfg_data  (cfg_data),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .busy      (busy),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
`ifdef MATRIX_CFG_READBACK_EN
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
`endif
      .cfg_bus   (cfg_bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Entry k drives one pin: top[0..4], bottom[0..4], left[0..3], right[0..3].
   function automatic bit legal(input int k, input logic [CW-1:0] w);
      int s = int'(w[2:0]);
      int i = int'(w[5:3]);
      int own_s;
      int own_i;
      if (s == 0) return 1'b1;
      if (s > 4) return 1'b0;
      if (i >= (((s == 1) || (s == 3)) ? NTB : NLR)) return 1'b0;
      if (k < NTB) begin
         own_s = 1; own_i = k;
      end else if (k < 2*NTB) begin
         own_s = 3; own_i = k - NTB;
      end else if (k < 2*NTB + NLR) begin
         own_s = 4; own_i = k - 2*NTB;
      end else begin
         own_s = 2; own_i = k - 2*NTB - NLR;
      end
      return !((s == own_s) && (i == own_i));
   endfunction

   function automatic logic [CW-1:0] rand_word();
      int r = $urandom_range(0, 9);
      logic [2:0] s;
      logic [2:0] i;
      if (r < 3) return {3'($urandom_range(0, 7)), 3'd0};
      s = 3'($urandom_range(1, 4));
      i = 3'($urandom_range(0, ((s == 3'd1) || (s == 3'd3)) ? NTB-1 : NLR-1));
      return {i, s};
   endfunction

   function automatic words_t rand_load(input bit inject);
      words_t w;
      for (int k = 0; k < NENT; k++) w[k] = rand_word();
      if (inject) w[$urandom_range(0, NENT-1)] = 6'($urandom_range(0, 63));
      return w;
   endfunction

   // Monitor: pops an expectation whenever the DUT pulses, and tracks cfg_bus every cycle.
   initial forever begin
      @(negedge clk);
      if (rst_q) begin
         exp_bus = '0;
         sbq.delete();
      end
      if ((sbq.size() > 0) && (cyc > sbq[0].cyc)) begin
         check("pulse_missing", BW'(cyc), BW'(sbq[0].cyc));
         void'(sbq.pop_front());
      end
      if (cfg_done || cfg_err) begin
         if (sbq.size() == 0) begin
            check("unexpected_pulse", BW'({cfg_done, cfg_err}), '0);
         end else begin
            e = sbq.pop_front();
            check("pulse_done", BW'(cfg_done), BW'(e.ok));
            check("pulse_err", BW'(cfg_err), BW'(!e.ok));
            check("pulse_cycle", BW'(cyc), BW'(e.cyc));
            if (e.ok) exp_bus = e.bus;
         end
      end
      check("cfg_bus", cfg_bus, exp_bus);
   end

   task automatic send(input logic [CW-1:0] w, input bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            cfg_valid = 1'b0;
            cfg_start = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         cfg_start = 1'b0;
      end
      check("ready_in_load", BW'(cfg_ready), BW'(1));
      check("busy_in_load", BW'(busy), BW'(1));
      cfg_valid = 1'b1;
      cfg_data  = w;
      @(negedge clk);
      last_xfer = cyc;
      cfg_valid = 1'b0;
      cfg_data  = 6'($urandom_range(0, 63));
   endtask

   // stop_at >= 0 interrupts the load at that word with abort (use_rst=0) or reset (use_rst=1).
   task automatic run_load(input words_t w, input bit gaps, input int stop_at, input bit use_rst);
      bit ok = 1'b1;
      logic [BW-1:0] pk = '0;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      for (int k = 0; k < NENT; k++) begin
         if (k == stop_at) begin
            cfg_valid = 1'b1;
            cfg_data  = w[k];
            if (use_rst) rst = 1'b1;
            else cfg_abort = 1'b1;
            @(negedge clk);
            rst       = 1'b0;
            cfg_abort = 1'b0;
            cfg_valid = 1'b0;
            check("stop_busy", BW'(busy), BW'(0));
            check("stop_ready", BW'(cfg_ready), BW'(0));
            if (use_rst) begin
               model_bus = '0;
               check("rst_bus", cfg_bus, '0);
            end
            @(negedge clk);
            return;
         end
         send(w[k], gaps);
         pk[k*CW +: CW] = w[k];
         if (!legal(k, w[k])) ok = 1'b0;
      end
      sbq.push_back('{ok, ok ? pk : model_bus, last_xfer + 1});
      check("commit_ready", BW'(cfg_ready), BW'(0));
      check("commit_busy", BW'(busy), BW'(1));
      @(negedge clk);
      check("idle_busy", BW'(busy), BW'(0));
      if (ok) model_bus = pk;
      repeat ($urandom_range(0, 1)) @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      words_t w;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("reset_ready", BW'(cfg_ready), BW'(0));
         check("reset_busy", BW'(busy), BW'(0));
      end
`ifdef MATRIX_CFG_READBACK_EN
      check("reset_rd_data", BW'(rd_data), BW'(0));
`endif

      w = '{default: '0}; w[0]  = 6'b011_010; run_load(w, 1'b0, -1, 1'b0);
      w = '{default: '0}; w[7]  = 6'b000_101; run_load(w, 1'b0, -1, 1'b0);
      w = '{default: '0}; w[2]  = 6'b010_001; run_load(w, 1'b0, -1, 1'b0);
      w = '{default: '0}; w[10] = 6'b100_010; run_load(w, 1'b0, -1, 1'b0);
      w = '{default: '0}; w[0]  = 6'b100_011; run_load(w, 1'b0, -1, 1'b0);
      w = '{default: '0}; w[14] = 6'b001_001; w[3] = 6'b001_100; run_load(w, 1'b1, -1, 1'b0);

`ifdef MATRIX_CFG_READBACK_EN
      rd_addr = 5'd14;
      @(negedge clk);
      check("readback_14", BW'(rd_data), BW'(6'b001_001));
      rd_addr = 5'd20;
      @(negedge clk);
      check("readback_oob", BW'(rd_data), BW'(0));
`endif

      run_load(rand_load(1'b0), 1'b1, 9, 1'b0);
      run_load(rand_load(1'b0), 1'b1, -1, 1'b0);

      for (int n = 0; n < 25; n++)
         run_load(rand_load(1'($urandom_range(0, 2) == 0)), 1'($urandom_range(0, 1)), -1, 1'b0);

`ifdef MATRIX_CFG_READBACK_EN
      for (int n = 0; n < 8; n++) begin
         logic [4:0] a = 5'($urandom_range(0, 31));
         rd_addr = a;
         @(negedge clk);
         check("readback_rand", BW'(rd_data), (a < 5'(NENT)) ? BW'(model_bus[int'(a)*CW +: CW]) : '0);
      end
`endif

      w = '{default: '0}; w[5] = 6'b000_001; run_load(w, 1'b0, -1, 1'b0);
      run_load(rand_load(1'b0), 1'b1, 12, 1'b1);
      run_load(rand_load(1'b0), 1'b0, -1, 1'b0);

      repeat (5) @(negedge clk);
      check("queue_drained", BW'(sbq.size()), BW'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_cfg_ctrl.md
Name: matrix_cfg_ctrl

Overview:
Configuration sequencer for the 5x4 programmable switch matrix. It accepts a stream of 6-bit routing words over a valid/ready handshake and stages them in shadow registers. It checks each word for legality, then commits the whole set atomically to the active configuration bus that drives the matrix's per-pin select registers. The matrix therefore never sees a partially loaded or illegal routing.

Parameters:
NTB, 5, pins per top/bottom edge
NLR, 4, pins per left/right edge
CW, 6, config word width: bits[2:0] side select, bits[5:3] pin index
NENT, 2*NTB+2*NLR (=18), total config entries (derived, localparam)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
cfg_start  input  1  begin a load sequence (sampled in IDLE only)
cfg_abort  input  1  abandon a load in progress
cfg_data  input  CW  config word
cfg_valid  input  1  cfg_data valid
cfg_ready  output  1  controller accepts a word this cycle
busy  output  1  high in LOAD or COMMIT
cfg_done  output  1  one-cycle pulse: new configuration committed
cfg_err  output  1  one-cycle pulse: load rejected, active config unchanged
cfg_bus  output  NENT*CW  active config, entry k at bits [k*CW +: CW]

Behaviour:
- Entry order k: 0..4 top[0..4]; 5..9 bottom[0..4]; 10..13 left[0..3]; 14..17 right[0..3].
- Side codes: 0 = undriven (high-Z); 1 = top; 2 = right; 3 = bottom; 4 = left.
- Reset: state IDLE; cfg_bus all zero (every matrix pin undriven); shadow all zero; cnt 0; err_flag 0; cfg_ready, busy, cfg_done, cfg_err all 0.
- FSM states: IDLE, LOAD, COMMIT.
- IDLE:
  - cfg_ready=0.
  - cfg_start=1 -> LOAD next cycle; cnt<=0; err_flag<=0.
- LOAD:
  - cfg_ready=1, busy=1.
  - Transfer occurs when cfg_valid & cfg_ready: shadow[cnt]<=cfg_data; cnt<=cnt+1.
  - On the transfer with cnt==NENT-1 -> COMMIT. cfg_ready is 0 in COMMIT, so no 19th word is accepted.
  - cfg_start in LOAD is ignored.
  - cfg_abort=1 -> IDLE next cycle. Shadow contents are don't-care; cfg_bus is unchanged; no done/err pulse. Abort wins over a simultaneous transfer, and that word is dropped.
- Legality check on each transferred word sets sticky err_flag if any of:
  - side code 5..7;
  - side 1/3 with index >= NTB;
  - side 2/4 with index >= NLR;
  - self-select, i.e. entry selects its own pin (e.g. k=2 with side 1 index 2). This would create a combinational loop.
  - Side code 0 is always legal; its index is ignored.
- COMMIT (exactly 1 cycle, busy=1):
  - If err_flag==0: cfg_bus<=shadow on this edge, and cfg_done=1 in the following cycle.
  - Else: cfg_err=1 in the following cycle and cfg_bus is unchanged.
  - Next state IDLE.
  - Latency: cfg_done is asserted 2 cycles after the last word's transfer edge, and cfg_bus updates on the same edge that raises cfg_done.
  - A cfg_start in the IDLE cycle right after COMMIT is accepted. Back-to-back loads need 1 idle cycle minimum.
- cfg_bus changes only on a successful COMMIT edge or on reset.
- rst asserted mid-LOAD or COMMIT: next edge returns to the reset state. cfg_bus is cleared to zero, so all pins are undriven.
- cnt width is $clog2(NENT); it never wraps because LOAD exits at NENT-1.

Optional Feature:
MATRIX_CFG_READBACK_EN:
- Defined: adds input rd_addr (5 bits) and output rd_data (CW bits).
  - rd_data is registered; it equals active entry rd_addr one cycle after rd_addr is presented.
  - rd_addr >= NENT returns 0.
  - After reset, rd_data=0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle 5 cycles -> cfg_bus==0, cfg_ready==0, busy==0, no pulses.
- Load 18 legal words, e.g. top[0]=6'b011_010 (right[3]) and all others 0, with cfg_valid held high -> 18 transfers; cfg_done pulses 2 cycles after the last transfer; cfg_bus[5:0]==6'b011_010 and all other bits 0.
- Load with word 7 = 6'b000_101 (side 5) -> cfg_err single pulse, no cfg_done; cfg_bus keeps the prior value.
- Legality edge cases: top[2]=6'b010_001 (self-select) -> cfg_err; left[0]=6'b100_010 (right index 4 >= NLR) -> cfg_err; top[0]=6'b100_011 (bottom index 4, legal) -> cfg_done.
- Randomly deassert cfg_valid during a load, then assert cfg_abort after 9 words -> IDLE next cycle, no pulses, cfg_bus unchanged. A fresh 18-word load afterwards succeeds.
- Assert rst at word 12 of a load following a successful commit -> cfg_bus==0 next cycle and state IDLE. With MATRIX_CFG_READBACK_EN defined, after a load with entry 14=6'b001_001, rd_addr=14 -> rd_data==6'b001_001 one cycle later, and rd_addr=20 -> rd_data==0.
